// File: rtl/copy_engine_fb_sink_if.sv
// Signal bundle between the copy-engine fabric, the VGA scanout, the external SRAM
// and the frame-buffer sink. The sink takes the slave view; the SoC/SRAM side takes the master view.
interface copy_engine_fb_sink_if;
    logic [9:0]  program_x;
    logic [9:0]  program_y;
    logic        program_write;
    logic [15:0] program_data;
    logic [1:0]  palette_index;
    logic        engine_execute;
    logic        engine_done;
    logic [19:0] src_addr;
    logic [15:0] src_data;
    logic        current_frame;
    logic [1:0]  palette_sel;
    logic        frame_sync;
    logic        vga_req;
    logic [9:0]  vga_x;
    logic [9:0]  vga_y;
    logic [15:0] vga_data;
    logic        vga_valid;
    logic        busy;
    logic        overflow;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    modport master (
        output program_x, program_y, program_write, program_data, palette_index,
        output engine_execute, engine_done, src_addr, frame_sync,
        output vga_req, vga_x, vga_y, sram_dq_in,
        input  src_data, current_frame, palette_sel, vga_data, vga_valid, busy, overflow,
        input  sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n,
        input  sram_ub_n, sram_lb_n
    );

    modport slave (
        input  program_x, program_y, program_write, program_data, palette_index,
        input  engine_execute, engine_done, src_addr, frame_sync,
        input  vga_req, vga_x, vga_y, sram_dq_in,
        output src_data, current_frame, palette_sel, vga_data, vga_valid, busy, overflow,
        output sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n,
        output sram_ub_n, sram_lb_n
    );
endinterface

// File: rtl/copy_engine_fb_sink.sv
// Copy-engine frame-buffer sink: buffers pixel writes, time-shares one SRAM between
// back-buffer writes, copy-engine source reads and VGA front-buffer reads, and swaps on vsync.
module copy_engine_fb_sink #(
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_W    = 640,
    parameter int FRAME_H    = 480
) (
    input logic                  clk_clk,
    input logic                  reset_reset_n,
    copy_engine_fb_sink_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {PH_READ, PH_WRITE} phase_t;
    typedef enum logic [1:0] {RD_NONE, RD_SRC, RD_VGA} rd_kind_t;

    function automatic logic [19:0] pix_addr(input logic frame, input logic [9:0] x,
                                             input logic [9:0] y);
        return {frame, 19'(y) * 19'(FRAME_W) + 19'(x)};
    endfunction

    phase_t      phase_q, phase_d;
    rd_kind_t    rd_kind_q, rd_kind_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic [35:0] fifo_mem_q [FIFO_DEPTH];
    logic [19:0] sram_addr_q, sram_addr_d;
    logic [15:0] sram_dq_out_q, sram_dq_out_d;
    logic        sram_dq_oe_q, sram_dq_oe_d;
    logic        sram_ce_n_q, sram_ce_n_d, sram_oe_n_q, sram_oe_n_d;
    logic        sram_we_n_q, sram_we_n_d, sram_bytes_n_q, sram_bytes_n_d;
    logic [15:0] src_data_q, src_data_d, vga_data_q, vga_data_d;
    logic        vga_valid_q, vga_valid_d;
    logic        current_frame_q, current_frame_d;
    logic [1:0]  palette_sel_q, palette_sel_d;
    logic        swap_pending_q, swap_pending_d;
    logic        overflow_q, overflow_d;
    logic        exec_prev_q, done_prev_q;

    logic        in_range, push_req, push, drop, do_pop, fifo_empty, fifo_full;
    logic        exec_rise, done_rise, swap_fire;
    logic [35:0] fifo_head;

    always_comb begin
        in_range   = (bus.program_x < 10'(FRAME_W)) && (bus.program_y < 10'(FRAME_H));
        push_req   = bus.program_write && in_range;
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
        fifo_head  = fifo_mem_q[rd_ptr_q];
        // VGA owns the slot whenever it asks; writes take only WRITE phases.
        do_pop     = !bus.vga_req && (phase_q == PH_WRITE) && !fifo_empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        push       = push_req && (!fifo_full || do_pop);
        drop       = push_req && fifo_full && !do_pop;
        exec_rise  = bus.engine_execute && !exec_prev_q;
        done_rise  = bus.engine_done && !done_prev_q;
        swap_fire  = bus.frame_sync && swap_pending_q && fifo_empty && sram_we_n_q;

        phase_d  = (phase_q == PH_READ) ? PH_WRITE : PH_READ;
        wr_ptr_d = push   ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && do_pop) begin
            count_d = count_q - 1'b1;
        end

        overflow_d      = drop ? 1'b1 : (exec_rise ? 1'b0 : overflow_q);
        current_frame_d = swap_fire ? ~current_frame_q : current_frame_q;
        palette_sel_d   = swap_fire ? bus.palette_index : palette_sel_q;
        swap_pending_d  = done_rise ? 1'b1 : (swap_fire ? 1'b0 : swap_pending_q);

        sram_addr_d    = sram_addr_q;
        sram_dq_out_d  = sram_dq_out_q;
        sram_dq_oe_d   = 1'b0;
        sram_ce_n_d    = 1'b1;
        sram_oe_n_d    = 1'b1;
        sram_we_n_d    = 1'b1;
        sram_bytes_n_d = 1'b1;
        rd_kind_d      = RD_NONE;
        if (bus.vga_req) begin
            sram_addr_d    = pix_addr(current_frame_q, bus.vga_x, bus.vga_y);
            sram_ce_n_d    = 1'b0;
            sram_oe_n_d    = 1'b0;
            sram_bytes_n_d = 1'b0;
            rd_kind_d      = RD_VGA;
        end else if (do_pop) begin
            sram_addr_d    = fifo_head[35:16];
            sram_dq_out_d  = fifo_head[15:0];
            sram_dq_oe_d   = 1'b1;
            sram_ce_n_d    = 1'b0;
            sram_we_n_d    = 1'b0;
            sram_bytes_n_d = 1'b0;
        end else begin
            sram_addr_d    = bus.src_addr;
            sram_ce_n_d    = 1'b0;
            sram_oe_n_d    = 1'b0;
            sram_bytes_n_d = 1'b0;
            rd_kind_d      = RD_SRC;
        end

        // Read data is captured one edge after the address was issued.
        src_data_d  = (rd_kind_q == RD_SRC) ? bus.sram_dq_in : src_data_q;
        vga_data_d  = (rd_kind_q == RD_VGA) ? bus.sram_dq_in : vga_data_q;
        vga_valid_d = (rd_kind_q == RD_VGA);
    end

    always_ff @(posedge clk_clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {pix_addr(~current_frame_q, bus.program_x, bus.program_y),
                                     bus.program_data};
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            phase_q         <= PH_READ;
            rd_kind_q       <= RD_NONE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            sram_addr_q     <= '0;
            sram_dq_out_q   <= '0;
            sram_dq_oe_q    <= 1'b0;
            sram_ce_n_q     <= 1'b1;
            sram_oe_n_q     <= 1'b1;
            sram_we_n_q     <= 1'b1;
            sram_bytes_n_q  <= 1'b1;
            src_data_q      <= '0;
            vga_data_q      <= '0;
            vga_valid_q     <= 1'b0;
            current_frame_q <= 1'b0;
            palette_sel_q   <= '0;
            swap_pending_q  <= 1'b0;
            overflow_q      <= 1'b0;
            exec_prev_q     <= 1'b0;
            done_prev_q     <= 1'b0;
        end else begin
            phase_q         <= phase_d;
            rd_kind_q       <= rd_kind_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            sram_addr_q     <= sram_addr_d;
            sram_dq_out_q   <= sram_dq_out_d;
            sram_dq_oe_q    <= sram_dq_oe_d;
            sram_ce_n_q     <= sram_ce_n_d;
            sram_oe_n_q     <= sram_oe_n_d;
            sram_we_n_q     <= sram_we_n_d;
            sram_bytes_n_q  <= sram_bytes_n_d;
            src_data_q      <= src_data_d;
            vga_data_q      <= vga_data_d;
            vga_valid_q     <= vga_valid_d;
            current_frame_q <= current_frame_d;
            palette_sel_q   <= palette_sel_d;
            swap_pending_q  <= swap_pending_d;
            overflow_q      <= overflow_d;
            exec_prev_q     <= bus.engine_execute;
            done_prev_q     <= bus.engine_done;
        end
    end

    assign bus.src_data      = src_data_q;
    assign bus.vga_data      = vga_data_q;
    assign bus.vga_valid     = vga_valid_q;
    assign bus.current_frame = current_frame_q;
    assign bus.palette_sel   = palette_sel_q;
    assign bus.overflow      = overflow_q;
    assign bus.busy          = !fifo_empty || !sram_we_n_q || swap_pending_q;
    assign bus.sram_addr     = sram_addr_q;
    assign bus.sram_dq_out   = sram_dq_out_q;
    assign bus.sram_dq_oe    = sram_dq_oe_q;
    assign bus.sram_ce_n     = sram_ce_n_q;
    assign bus.sram_oe_n     = sram_oe_n_q;
    assign bus.sram_we_n     = sram_we_n_q;
    assign bus.sram_ub_n     = sram_bytes_n_q;
    assign bus.sram_lb_n     = sram_bytes_n_q;
endmodule

// File: tb/tb_copy_engine_fb_sink.sv
// Scoreboard bench for copy_engine_fb_sink: SRAM behavioural model, expected-write and
// expected-VGA queues filled at stimulus time, and a negedge monitor that pops and compares.
module tb_copy_engine_fb_sink;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    copy_engine_fb_sink_if bus();

    copy_engine_fb_sink #(.FIFO_DEPTH(16), .FRAME_W(640), .FRAME_H(480)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    bit prev_we_low = 1'b0;
    int wr_seen = 0;
    int vga_seen = 0;
    logic [35:0] exp_wr_q[$];
    logic [15:0] exp_vga_q[$];
    logic [15:0] model_mem[logic [19:0]];
    logic [15:0] sram_mem[logic [19:0]];
    logic [19:0] written[$];
    logic        cur_frame_m = 1'b0;

    function automatic logic [15:0] hash16(input logic [19:0] a);
        return a[15:0] ^ {a[19:16], 12'h5A5};
    endfunction

    function automatic logic [15:0] model_rd(input logic [19:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return hash16(a);
    endfunction

    function automatic logic [19:0] pix(input logic f, input int x, input int y);
        int lin;
        lin = y * 640 + x;
        return {f, lin[18:0]};
    endfunction

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (mon_en && bus.vga_req)
            exp_vga_q.push_back(model_rd(pix(cur_frame_m, int'(bus.vga_x), int'(bus.vga_y))));
        #1;
    endtask

    task automatic pwrite(input int x, input int y, input logic [15:0] d, input bit accept);
        logic [19:0] a;
        bus.program_x     = 10'(x);
        bus.program_y     = 10'(y);
        bus.program_data  = d;
        bus.program_write = 1'b1;
        if (mon_en && accept && x < 640 && y < 480) begin
            a = pix(~cur_frame_m, x, y);
            exp_wr_q.push_back({a, d});
            model_mem[a] = d;
            written.push_back(a);
        end
        tick();
        bus.program_write = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_wr_q.size() == 0 && exp_vga_q.size() == 0) break;
            tick();
        end
        chk("drain_wr_q", 36'(exp_wr_q.size()), 36'd0);
        chk("drain_vga_q", 36'(exp_vga_q.size()), 36'd0);
    endtask

    // SRAM behavioural model: writes land at the negedge, reads present data for the next edge.
    initial begin
        bus.sram_dq_in = '0;
        forever begin
            @(negedge clk);
            if (!bus.sram_ce_n && !bus.sram_we_n) sram_mem[bus.sram_addr] = bus.sram_dq_out;
            if (!bus.sram_ce_n && !bus.sram_oe_n)
                bus.sram_dq_in = sram_mem.exists(bus.sram_addr) ? sram_mem[bus.sram_addr]
                                                               : hash16(bus.sram_addr);
            else
                bus.sram_dq_in = 16'h0;
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (!bus.sram_we_n) begin
                    wr_seen++;
                    if (exp_wr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                                 bus.sram_addr, bus.sram_dq_out);
                    end else begin
                        chk("sram_write", {bus.sram_addr, bus.sram_dq_out}, exp_wr_q.pop_front());
                    end
                    chk("write_strobes", {31'd0, bus.sram_dq_oe, bus.sram_oe_n, bus.sram_ce_n,
                                          bus.sram_ub_n, bus.sram_lb_n}, 36'b11000);
                    chk("write_spacing", 36'(prev_we_low), 36'd0);
                end
                if (bus.vga_valid) begin
                    vga_seen++;
                    if (exp_vga_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_vga_valid: data %0h, none expected", bus.vga_data);
                    end else begin
                        chk("vga_data", 36'(bus.vga_data), 36'(exp_vga_q.pop_front()));
                    end
                end
            end
            prev_we_low = !bus.sram_we_n;
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        int vbase;
        bit seen;
        logic [19:0] a;
        bus.program_x = '0; bus.program_y = '0; bus.program_write = 1'b0; bus.program_data = '0;
        bus.palette_index = '0; bus.engine_execute = 1'b0; bus.engine_done = 1'b0;
        bus.src_addr = '0; bus.frame_sync = 1'b0; bus.vga_req = 1'b0;
        bus.vga_x = '0; bus.vga_y = '0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Reset asserted while a write strobe is active
        pwrite(5, 2, 16'h1234, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = !bus.sram_we_n;
        end
        chk("we_low_before_reset", 36'(seen), 36'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_strobes", {31'd0, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n,
                            bus.sram_ub_n, bus.sram_lb_n}, 36'h1F);
        chk("rst_dq_oe", 36'(bus.sram_dq_oe), 36'd0);
        chk("rst_sram_addr", 36'(bus.sram_addr), 36'd0);
        chk("rst_sram_dq_out", 36'(bus.sram_dq_out), 36'd0);
        chk("rst_src_data", 36'(bus.src_data), 36'd0);
        chk("rst_vga", {19'd0, bus.vga_valid, bus.vga_data}, 36'd0);
        chk("rst_flags", {32'd0, bus.busy, bus.overflow, bus.current_frame, 1'b0}, 36'd0);
        chk("rst_palette", 36'(bus.palette_sel), 36'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("post_rst_we_n", 36'(bus.sram_we_n), 36'd1);
        chk("post_rst_busy", 36'(bus.busy), 36'd0);
        mon_en = 1'b1;

        // Single pixel write into the back buffer
        base = wr_seen;
        pwrite(5, 2, 16'hBEEF, 1'b1);
        repeat (4) tick();
        chk("beef_write_count", 36'(wr_seen - base), 36'd1);
        chk("beef_addr_expect", 36'(pix(1'b1, 5, 2)), 36'h80505);

        // Out-of-range pixels are discarded silently
        base = wr_seen;
        pwrite(640, 0, 16'h1111, 1'b1);
        pwrite(0, 480, 16'h2222, 1'b1);
        repeat (4) tick();
        chk("oor_write_count", 36'(wr_seen - base), 36'd0);
        chk("oor_overflow", 36'(bus.overflow), 36'd0);
        chk("oor_busy", 36'(bus.busy), 36'd0);

        // Burst with the drain stalled by continuous VGA reads
        wait_drain(20);
        base = wr_seen;
        vbase = vga_seen;
        bus.vga_req = 1'b1; bus.vga_x = 10'd1; bus.vga_y = 10'd1;
        for (int i = 0; i < 20; i++) pwrite(i, 3, 16'(16'hA000 + i), i < 16);
        chk("stall_no_writes", 36'(wr_seen - base), 36'd0);
        chk("burst_overflow", 36'(bus.overflow), 36'd1);
        bus.vga_req = 1'b0;
        repeat (2) tick();
        chk("vga_pulse_count", 36'(vga_seen - vbase), 36'd20);
        wait_drain(60);
        chk("burst_write_count", 36'(wr_seen - base), 36'd16);
        chk("overflow_sticky", 36'(bus.overflow), 36'd1);
        bus.engine_execute = 1'b1;
        tick();
        chk("overflow_cleared", 36'(bus.overflow), 36'd0);
        bus.engine_execute = 1'b0;

        // Swap deferred while writes are queued, then taken on a later vsync
        pwrite(10, 10, 16'h0C01, 1'b1);
        pwrite(11, 10, 16'h0C02, 1'b1);
        bus.engine_done = 1'b1;
        pwrite(12, 10, 16'h0C03, 1'b1);
        bus.frame_sync = 1'b1;
        tick();
        bus.frame_sync = 1'b0;
        chk("swap_deferred_frame", 36'(bus.current_frame), 36'd0);
        chk("swap_deferred_busy", 36'(bus.busy), 36'd1);
        wait_drain(30);
        repeat (2) tick();
        bus.engine_done = 1'b0;
        bus.palette_index = 2'd2;
        bus.frame_sync = 1'b1;
        tick();
        bus.frame_sync = 1'b0;
        cur_frame_m = 1'b1;
        chk("swap_frame", 36'(bus.current_frame), 36'd1);
        chk("swap_palette", 36'(bus.palette_sel), 36'd2);
        chk("swap_busy_clear", 36'(bus.busy), 36'd0);

        // Randomized traffic: sparse writes (some out of range), VGA reads, src address churn
        for (int i = 0; i < 400; i++) begin
            bus.vga_req = ($urandom_range(0, 3) == 0);
            bus.vga_x = 10'($urandom_range(0, 639));
            bus.vga_y = 10'($urandom_range(0, 479));
            if ($urandom_range(0, 15) == 0) bus.src_addr = 20'($urandom);
            if ($urandom_range(0, 7) == 0)
                pwrite($urandom_range(0, 699), $urandom_range(0, 519), 16'($urandom), 1'b1);
            else
                tick();
        end
        bus.vga_req = 1'b0;
        wait_drain(80);
        chk("random_overflow", 36'(bus.overflow), 36'd0);

        // Source reads return what was written (back buffer) or SRAM preload (front buffer)
        for (int i = 0; i < 6; i++) begin
            if (written.size() > 0) a = written[$urandom_range(0, written.size() - 1)];
            else a = pix(1'b0, i, i);
            bus.src_addr = a;
            repeat (6) tick();
            chk("src_readback", 36'(bus.src_data), 36'(model_rd(a)));
        end
        bus.src_addr = pix(1'b1, 7, 400);
        repeat (6) tick();
        chk("src_front", 36'(bus.src_data), 36'(model_rd(pix(1'b1, 7, 400))));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
